ctrl_pipe: RTL and testbench

- Pipelined control unit for the 5-stage RV32I core.
- Decodes the instruction in D (main decode plus ALU decode). Carries the control word through the ID/EX, EX/MEM and MEM/WB registers, and resolves the branch/jump PC select in E.
- Over the single-cycle control path it adds: full branch set, jalr, lui/auipc, flush bubbles and an illegal-opcode flag.

---
 rtl/ctrl_pkg.sv | 74 +++++++
 rtl/ctrl_decode.sv | 96 +++++++++
 rtl/ctrl_pipe.sv | 102 ++++++++++
 tb/tb_ctrl_pipe.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings and the E-stage control word for the pipelined RV32I control unit.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLT   = 4'b0101,
        ALU_SLTU  = 4'b0110,
        ALU_SLL   = 4'b0111,
        ALU_SRL   = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // All-zero value is the bubble: no write, no branch, no jump.
    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        alu_src_a;
        logic        alu_src_b;
        logic [2:0]  funct3;
        alu_op_e     alu_control;
    } ctrl_e_t;

    // funct7b5 means sub only for register-register ops; for shifts it always means arithmetic.
    function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic funct7b5,
                                           input logic is_rtype);
        alu_op_e op;
        op = ALU_ADD;
        case (funct3)
            3'b000:  op = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational D-stage decoder: main decode, ALU decode and illegal-instruction detection.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit EXT_BRANCH = 1'b1,
    parameter bit EXT_UPPER  = 1'b1
) (
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output ctrl_e_t    ctrl,
    output imm_src_e   imm_src,
    output logic       illegal
);

    always_comb begin
        ctrl    = '0;
        imm_src = IMM_I;
        illegal = 1'b0;
        case (op)
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.alu_src_b  = 1'b1;
                ctrl.alu_control = ALU_ADD;
            end
            OP_STORE: begin
                imm_src         = IMM_S;
                ctrl.mem_write  = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                ctrl.alu_control = ALU_ADD;
            end
            OP_RTYPE: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_control = alu_decode(funct3, funct7b5, 1'b1);
            end
            OP_ITYPE: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_b   = 1'b1;
                ctrl.alu_control = alu_decode(funct3, funct7b5, 1'b0);
            end
            OP_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011 || (!EXT_BRANCH && funct3 != 3'b000)) begin
                    illegal = 1'b1;
                end else begin
                    imm_src          = IMM_B;
                    ctrl.branch      = 1'b1;
                    ctrl.funct3      = funct3;
                    ctrl.alu_control = ALU_SUB;
                end
            end
            OP_JAL: begin
                imm_src         = IMM_J;
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.jump       = 1'b1;
            end
            OP_JALR: begin
                if (!EXT_UPPER) begin
                    illegal = 1'b1;
                end else begin
                    ctrl.reg_write   = 1'b1;
                    ctrl.result_src  = RES_PC4;
                    ctrl.jump        = 1'b1;
                    ctrl.jalr        = 1'b1;
                    ctrl.alu_src_b   = 1'b1;
                    ctrl.alu_control = ALU_ADD;
                end
            end
            // lui/auipc write rd with the ALU result like any other ALU op.
            OP_LUI: begin
                if (!EXT_UPPER) begin
                    illegal = 1'b1;
                end else begin
                    imm_src          = IMM_U;
                    ctrl.reg_write   = 1'b1;
                    ctrl.alu_src_b   = 1'b1;
                    ctrl.alu_control = ALU_PASSB;
                end
            end
            OP_AUIPC: begin
                if (!EXT_UPPER) begin
                    illegal = 1'b1;
                end else begin
                    imm_src          = IMM_U;
                    ctrl.reg_write   = 1'b1;
                    ctrl.alu_src_a   = 1'b1;
                    ctrl.alu_src_b   = 1'b1;
                    ctrl.alu_control = ALU_ADD;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decode in D, ID/EX, EX/MEM and MEM/WB control registers, branch resolve in E.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter bit EXT_BRANCH = 1'b1,
    parameter bit EXT_UPPER  = 1'b1,
    parameter int ALUCTRL_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           OpD,
    input  logic [2:0]           Funct3D,
    input  logic                 Funct7b5D,
    input  logic                 FlushE,
    input  logic                 ZeroE,
    input  logic                 NegE,
    input  logic                 OvfE,
    input  logic                 CarryE,
    output logic [2:0]           ImmSrcD,
    output logic                 IllegalD,
    output logic                 RegWriteE,
    output logic [1:0]           ResultSrcE,
    output logic                 MemWriteE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcAE,
    output logic                 ALUSrcBE,
    output logic                 PCSrcE,
    output logic                 JalrE,
    output logic                 RegWriteM,
    output logic [1:0]           ResultSrcM,
    output logic                 MemWriteM,
    output logic                 RegWriteW,
    output logic [1:0]           ResultSrcW
);

    ctrl_e_t  ctrl_d;
    ctrl_e_t  ctrl_e;
    imm_src_e imm_src_d;
    logic     taken;

    ctrl_decode #(
        .EXT_BRANCH(EXT_BRANCH),
        .EXT_UPPER (EXT_UPPER)
    ) u_decode (
        .op      (OpD),
        .funct3  (Funct3D),
        .funct7b5(Funct7b5D),
        .ctrl    (ctrl_d),
        .imm_src (imm_src_d),
        .illegal (IllegalD)
    );

    assign ImmSrcD = imm_src_d;

    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            ctrl_e <= '0;
        end else begin
            ctrl_e <= ctrl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            MemWriteM  <= 1'b0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
        end else begin
            RegWriteM  <= ctrl_e.reg_write;
            ResultSrcM <= ctrl_e.result_src;
            MemWriteM  <= ctrl_e.mem_write;
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
        end
    end

    // Flags come from rs1 - rs2; CarryE=1 means no borrow, i.e. rs1 >= rs2 unsigned.
    always_comb begin
        taken = 1'b0;
        case (ctrl_e.funct3)
            3'b000:  taken = ZeroE;
            3'b001:  taken = ~ZeroE;
            3'b100:  taken = NegE ^ OvfE;
            3'b101:  taken = ~(NegE ^ OvfE);
            3'b110:  taken = ~CarryE;
            3'b111:  taken = CarryE;
            default: taken = 1'b0;
        endcase
    end

    assign PCSrcE      = (ctrl_e.branch & taken) | ctrl_e.jump;
    assign RegWriteE   = ctrl_e.reg_write;
    assign ResultSrcE  = ctrl_e.result_src;
    assign MemWriteE   = ctrl_e.mem_write;
    assign ALUControlE = ALUCTRL_W'(ctrl_e.alu_control);
    assign ALUSrcAE    = ctrl_e.alu_src_a;
    assign ALUSrcBE    = ctrl_e.alu_src_b;
    assign JalrE       = ctrl_e.jalr;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: full-feature instance plus a reduced instance (no extended branches/upper ops).
module tb_ctrl_pipe;

    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] RTYPE  = 7'b0110011;
    localparam logic [6:0] ITYPE  = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    logic       clk;
    logic       reset;
    logic [6:0] OpD;
    logic [2:0] Funct3D;
    logic       Funct7b5D;
    logic       FlushE;
    logic       ZeroE, NegE, OvfE, CarryE;

    logic [2:0] ImmSrcD;
    logic       IllegalD, RegWriteE, MemWriteE, ALUSrcAE, ALUSrcBE, PCSrcE, JalrE;
    logic [1:0] ResultSrcE, ResultSrcM, ResultSrcW;
    logic [3:0] ALUControlE;
    logic       RegWriteM, MemWriteM, RegWriteW;

    logic [2:0] r_imm_src;
    logic       r_illegal, r_reg_write_e, r_mem_write_e, r_src_a, r_src_b, r_pcsrc, r_jalr;
    logic [1:0] r_res_e, r_res_m, r_res_w;
    logic [3:0] r_alu;
    logic       r_reg_write_m, r_mem_write_m, r_reg_write_w;

    int checks   = 0;
    int failures = 0;
    logic [2:0] exp_q[$];

    ctrl_pipe #(.EXT_BRANCH(1'b1), .EXT_UPPER(1'b1), .ALUCTRL_W(4)) dut (
        .clk(clk), .reset(reset), .OpD(OpD), .Funct3D(Funct3D), .Funct7b5D(Funct7b5D),
        .FlushE(FlushE), .ZeroE(ZeroE), .NegE(NegE), .OvfE(OvfE), .CarryE(CarryE),
        .ImmSrcD(ImmSrcD), .IllegalD(IllegalD), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .MemWriteE(MemWriteE), .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
        .PCSrcE(PCSrcE), .JalrE(JalrE), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
    );

    ctrl_pipe #(.EXT_BRANCH(1'b0), .EXT_UPPER(1'b0), .ALUCTRL_W(4)) dut_min (
        .clk(clk), .reset(reset), .OpD(OpD), .Funct3D(Funct3D), .Funct7b5D(Funct7b5D),
        .FlushE(FlushE), .ZeroE(ZeroE), .NegE(NegE), .OvfE(OvfE), .CarryE(CarryE),
        .ImmSrcD(r_imm_src), .IllegalD(r_illegal), .RegWriteE(r_reg_write_e), .ResultSrcE(r_res_e),
        .MemWriteE(r_mem_write_e), .ALUControlE(r_alu), .ALUSrcAE(r_src_a), .ALUSrcBE(r_src_b),
        .PCSrcE(r_pcsrc), .JalrE(r_jalr), .RegWriteM(r_reg_write_m), .ResultSrcM(r_res_m),
        .MemWriteM(r_mem_write_m), .RegWriteW(r_reg_write_w), .ResultSrcW(r_res_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        OpD       = op;
        Funct3D   = f3;
        Funct7b5D = f7;
    endtask

    task automatic flags(input logic z, input logic n, input logic v, input logic c);
        ZeroE  = z;
        NegE   = n;
        OvfE   = v;
        CarryE = c;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        FlushE = 1'b0;
        drive(JAL, 3'b000, 1'b0);
        flags(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        step();
        checks++;
        if ({RegWriteE, MemWriteE, PCSrcE, JalrE, ResultSrcE} !== 6'b0) begin
            failures++;
            $display("FAIL reset_e_stage: got %b want 000000", {RegWriteE, MemWriteE, PCSrcE, JalrE, ResultSrcE});
        end
        checks++;
        if ({RegWriteM, MemWriteM, ResultSrcM, RegWriteW, ResultSrcW} !== 7'b0) begin
            failures++;
            $display("FAIL reset_mw_stage: got %b want 0000000", {RegWriteM, MemWriteM, ResultSrcM, RegWriteW, ResultSrcW});
        end
        drive(7'b0000000, 3'b000, 1'b0);
        reset = 1'b0;
        step();
    endtask

    task automatic test_load_latency();
        drive(LW, 3'b010, 1'b0);
        #1;
        checks++;
        if ({IllegalD, ImmSrcD} !== 4'b0000) begin
            failures++;
            $display("FAIL lw_decode_d: got %b want 0000", {IllegalD, ImmSrcD});
        end
        step();
        drive(7'b0000000, 3'b000, 1'b0);
        checks++;
        if ({RegWriteE, ResultSrcE, ALUSrcBE, ALUControlE} !== 8'b1_01_1_0000) begin
            failures++;
            $display("FAIL lw_e_stage: got %b want 10110000", {RegWriteE, ResultSrcE, ALUSrcBE, ALUControlE});
        end
        step();
        checks++;
        if ({RegWriteM, ResultSrcM, RegWriteE} !== 4'b1010) begin
            failures++;
            $display("FAIL lw_m_stage: got %b want 1010", {RegWriteM, ResultSrcM, RegWriteE});
        end
        step();
        checks++;
        if ({RegWriteW, ResultSrcW} !== 3'b101) begin
            failures++;
            $display("FAIL lw_w_stage: got %b want 101", {RegWriteW, ResultSrcW});
        end
    endtask

    task automatic test_branches();
        // {funct3, Z, N, V, C, expected PCSrcE}
        logic [7:0] vec [9];
        vec[0] = {3'b000, 4'b1000, 1'b1};
        vec[1] = {3'b000, 4'b0000, 1'b0};
        vec[2] = {3'b001, 4'b0000, 1'b1};
        vec[3] = {3'b001, 4'b1000, 1'b0};
        vec[4] = {3'b100, 4'b0110, 1'b0};
        vec[5] = {3'b100, 4'b0100, 1'b1};
        vec[6] = {3'b101, 4'b0100, 1'b0};
        vec[7] = {3'b110, 4'b0000, 1'b1};
        vec[8] = {3'b111, 4'b0001, 1'b1};
        for (int i = 0; i < 9; i++) begin
            drive(BRANCH, vec[i][7:5], 1'b0);
            #1;
            checks++;
            if ({IllegalD, ImmSrcD} !== 4'b0010) begin
                failures++;
                $display("FAIL branch_decode_%0d: got %b want 0010", i, {IllegalD, ImmSrcD});
            end
            step();
            flags(vec[i][4], vec[i][3], vec[i][2], vec[i][1]);
            checks++;
            if ({PCSrcE, ALUControlE, RegWriteE} !== {vec[i][0], 4'b0001, 1'b0}) begin
                failures++;
                $display("FAIL branch_resolve_%0d: got %b want %b", i, {PCSrcE, ALUControlE, RegWriteE},
                         {vec[i][0], 4'b0001, 1'b0});
            end
        end
        drive(7'b0000000, 3'b000, 1'b0);
        flags(1'b0, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_flush();
        drive(SW, 3'b010, 1'b0);
        FlushE = 1'b0;
        step();
        checks++;
        if ({MemWriteE, ALUSrcBE} !== 2'b11) begin
            failures++;
            $display("FAIL sw_unflushed_e: got %b want 11", {MemWriteE, ALUSrcBE});
        end
        FlushE = 1'b1;
        step();
        FlushE = 1'b0;
        drive(7'b0000000, 3'b000, 1'b0);
        checks++;
        if ({MemWriteE, MemWriteM} !== 2'b01) begin
            failures++;
            $display("FAIL sw_flush_e: got %b want 01", {MemWriteE, MemWriteM});
        end
        step();
        checks++;
        if (MemWriteM !== 1'b0) begin
            failures++;
            $display("FAIL sw_flush_m: got %b want 0", MemWriteM);
        end
        drive(JAL, 3'b000, 1'b0);
        FlushE = 1'b1;
        step();
        FlushE = 1'b0;
        #1;
        checks++;
        if ({PCSrcE, RegWriteE, ResultSrcE} !== 4'b0000) begin
            failures++;
            $display("FAIL jal_flush_e: got %b want 0000", {PCSrcE, RegWriteE, ResultSrcE});
        end
        step();
        checks++;
        if ({PCSrcE, RegWriteE, ResultSrcE, JalrE} !== 5'b11100) begin
            failures++;
            $display("FAIL jal_unflushed_e: got %b want 11100", {PCSrcE, RegWriteE, ResultSrcE, JalrE});
        end
        drive(7'b0000000, 3'b000, 1'b0);
        step();
    endtask

    task automatic test_jalr_upper();
        drive(JALR, 3'b000, 1'b0);
        #1;
        checks++;
        if ({IllegalD, ImmSrcD} !== 4'b0000) begin
            failures++;
            $display("FAIL jalr_decode_d: got %b want 0000", {IllegalD, ImmSrcD});
        end
        step();
        drive(LUI, 3'b000, 1'b0);
        #1;
        checks++;
        if ({JalrE, PCSrcE, ALUControlE, ALUSrcBE} !== 7'b1100001) begin
            failures++;
            $display("FAIL jalr_e_stage: got %b want 1100001", {JalrE, PCSrcE, ALUControlE, ALUSrcBE});
        end
        checks++;
        if (ImmSrcD !== 3'b100) begin
            failures++;
            $display("FAIL lui_imm_src: got %b want 100", ImmSrcD);
        end
        step();
        drive(AUIPC, 3'b000, 1'b0);
        checks++;
        if ({ALUControlE, ALUSrcAE, ALUSrcBE, JalrE} !== 7'b1010010) begin
            failures++;
            $display("FAIL lui_e_stage: got %b want 1010010", {ALUControlE, ALUSrcAE, ALUSrcBE, JalrE});
        end
        step();
        drive(7'b0000000, 3'b000, 1'b0);
        checks++;
        if ({ResultSrcW, ALUControlE, ALUSrcAE, ALUSrcBE} !== 8'b10000011) begin
            failures++;
            $display("FAIL jalr_w_auipc_e: got %b want 10000011", {ResultSrcW, ALUControlE, ALUSrcAE, ALUSrcBE});
        end
        step();
    endtask

    task automatic test_alu_decode();
        // {op, funct3, funct7b5, expected ALUControlE, expected ALUSrcBE}
        logic [15:0] vec [6];
        vec[0] = {RTYPE, 3'b000, 1'b1, 4'b0001, 1'b0};
        vec[1] = {ITYPE, 3'b000, 1'b1, 4'b0000, 1'b1};
        vec[2] = {ITYPE, 3'b101, 1'b1, 4'b1001, 1'b1};
        vec[3] = {RTYPE, 3'b101, 1'b0, 4'b1000, 1'b0};
        vec[4] = {RTYPE, 3'b011, 1'b0, 4'b0110, 1'b0};
        vec[5] = {ITYPE, 3'b111, 1'b0, 4'b0010, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(vec[i][15:9], vec[i][8:6], vec[i][5]);
            step();
            checks++;
            if ({ALUControlE, ALUSrcBE, RegWriteE} !== {vec[i][4:0], 1'b1}) begin
                failures++;
                $display("FAIL alu_decode_%0d: got %b want %b", i, {ALUControlE, ALUSrcBE, RegWriteE},
                         {vec[i][4:0], 1'b1});
            end
        end
        drive(7'b0000000, 3'b000, 1'b0);
        step();
    endtask

    task automatic test_back_to_back();
        // {op, expected {RegWriteW, ResultSrcW} three cycles later}
        logic [9:0] seq [5];
        logic [2:0] exp_w;
        seq[0] = {LW, 3'b101};
        seq[1] = {JAL, 3'b110};
        seq[2] = {RTYPE, 3'b100};
        seq[3] = {SW, 3'b000};
        seq[4] = {ITYPE, 3'b100};
        for (int i = 0; i < 8; i++) begin
            if (i < 5) begin
                drive(seq[i][9:3], 3'b000, 1'b0);
                exp_q.push_back(seq[i][2:0]);
            end else begin
                drive(7'b0000000, 3'b000, 1'b0);
                exp_q.push_back(3'b000);
            end
            step();
            if (i >= 2) begin
                exp_w = exp_q.pop_front();
                checks++;
                if ({RegWriteW, ResultSrcW} !== exp_w) begin
                    failures++;
                    $display("FAIL b2b_w_%0d: got %b want %b", i - 2, {RegWriteW, ResultSrcW}, exp_w);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_illegal();
        drive(7'b1111111, 3'b000, 1'b0);
        #1;
        checks++;
        if ({IllegalD, r_illegal} !== 2'b11) begin
            failures++;
            $display("FAIL illegal_opcode: got %b want 11", {IllegalD, r_illegal});
        end
        step();
        checks++;
        if ({RegWriteE, MemWriteE, PCSrcE} !== 3'b000) begin
            failures++;
            $display("FAIL illegal_opcode_e: got %b want 000", {RegWriteE, MemWriteE, PCSrcE});
        end
        drive(BRANCH, 3'b010, 1'b0);
        #1;
        checks++;
        if (IllegalD !== 1'b1) begin
            failures++;
            $display("FAIL branch_f3_010_illegal: got %b want 1", IllegalD);
        end
        step();
        flags(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (PCSrcE !== 1'b0) begin
            failures++;
            $display("FAIL branch_f3_010_pcsrc: got %b want 0", PCSrcE);
        end
        drive(BRANCH, 3'b001, 1'b0);
        #1;
        checks++;
        if ({r_illegal, IllegalD} !== 2'b10) begin
            failures++;
            $display("FAIL bne_min_illegal: got %b want 10", {r_illegal, IllegalD});
        end
        step();
        flags(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({r_pcsrc, PCSrcE} !== 2'b01) begin
            failures++;
            $display("FAIL bne_min_pcsrc: got %b want 01", {r_pcsrc, PCSrcE});
        end
        drive(BRANCH, 3'b000, 1'b0);
        step();
        flags(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({r_illegal, r_pcsrc} !== 2'b01) begin
            failures++;
            $display("FAIL beq_min_taken: got %b want 01", {r_illegal, r_pcsrc});
        end
        drive(JALR, 3'b000, 1'b0);
        #1;
        checks++;
        if ({r_illegal, IllegalD} !== 2'b10) begin
            failures++;
            $display("FAIL jalr_min_illegal: got %b want 10", {r_illegal, IllegalD});
        end
        step();
        checks++;
        if ({r_pcsrc, r_jalr, r_reg_write_e, PCSrcE, JalrE} !== 5'b00011) begin
            failures++;
            $display("FAIL jalr_min_e: got %b want 00011", {r_pcsrc, r_jalr, r_reg_write_e, PCSrcE, JalrE});
        end
        drive(7'b0000000, 3'b000, 1'b0);
        flags(1'b0, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_reset_mid();
        drive(JAL, 3'b000, 1'b0);
        step();
        checks++;
        if (PCSrcE !== 1'b1) begin
            failures++;
            $display("FAIL jal_before_reset: got %b want 1", PCSrcE);
        end
        reset  = 1'b1;
        FlushE = 1'b1;
        step();
        reset  = 1'b0;
        FlushE = 1'b0;
        drive(7'b0000000, 3'b000, 1'b0);
        checks++;
        if ({PCSrcE, RegWriteE, RegWriteM, ResultSrcM, RegWriteW} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_mid_jal: got %b want 00000", {PCSrcE, RegWriteE, RegWriteM, ResultSrcM, RegWriteW});
        end
        step();
        checks++;
        if ({RegWriteM, RegWriteW} !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_drain: got %b want 00", {RegWriteM, RegWriteW});
        end
    endtask

    initial begin
        reset = 1'b1;
        FlushE = 1'b0;
        OpD = 7'b0;
        Funct3D = 3'b0;
        Funct7b5D = 1'b0;
        ZeroE = 1'b0;
        NegE = 1'b0;
        OvfE = 1'b0;
        CarryE = 1'b0;
        test_reset();
        test_load_latency();
        test_branches();
        test_flush();
        test_jalr_upper();
        test_alu_decode();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
